sevseg_scan_mux: RTL and testbench
==================================

// Module: sevseg_scan_mux
// PURPOSE
//  Time-multiplexed driver for a bank of common-anode seven-segment displays.
//  Consumes the packed active-low segment bus produced by the counter/decoder
//  stage (7 bits per digit, digit 0 in bits [6:0]). Drives one shared segment
//  bus plus one-hot digit enables, scanning digits round-robin. Inserts a blank
//  interval per slot for anti-ghosting and snapshots each digit so mid-slot
//  input changes never tear the display.
// PARAMETERS
//  DIGITS        4      number of digits scanned (>=1)
//  REFRESH_DIV   50000  clock cycles per digit slot (>=2)
//  BLANK_CYCLES  16     blanked cycles at start of each slot (1..REFRESH_DIV-1)
//  EN_ACTIVE_LOW 1      1: dig_en active-low; 0: dig_en active-high
// PORTS
//  clk         in   1           system clock
//  rst         in   1           async reset, active-high
//  en          in   1           scan enable; low = display off, scan frozen
//  seg_in      in   7*DIGITS    packed active-low segment patterns
//  dp_in       in   DIGITS      decimal points, active-low, bit i = digit i
//  seg_out     out  7           shared segment bus, active-low
//  dp_out      out  1           shared decimal point, active-low
//  dig_en      out  DIGITS      one-hot digit enable (polarity per EN_ACTIVE_LOW)
//  frame_tick  out  1           1-cycle pulse when scan wraps from DIGITS-1 to 0
// BEHAVIOUR
//  Reset (async on rst=1): prescaler cnt=0, idx=0, snapshot=7'h7F/dp=1,
//   seg_out=7'h7F, dp_out=1, dig_en=all inactive, frame_tick=0.
//  Prescaler: when en=1, cnt counts 0..REFRESH_DIV-1, then returns to 0.
//   On the cnt==REFRESH_DIV-1 edge, idx advances; DIGITS-1 wraps to 0.
//  Per-slot FSM, derived from cnt:
//   BLANK: cnt < BLANK_CYCLES. All digits off, seg_out=7'h7F, dp_out=1.
//   DRIVE: cnt >= BLANK_CYCLES. dig_en[idx] active, others inactive;
//    seg_out/dp_out come from snapshot.
//  Snapshot: seg_in[7*idx+:7] and dp_in[idx] are captured on the edge where
//   cnt==BLANK_CYCLES-1. Input changes during DRIVE take effect next visit.
//  Output latency: all outputs registered. The state for a cnt value is
//   visible one clock after cnt holds that value.
//  frame_tick: high for exactly one cycle, coincident with the first BLANK
//   output cycle of digit 0 after a wrap. Not asserted on the first slot
//   after reset.
//  en=0: cnt and idx hold. Outputs go blank/inactive on the next edge.
//   frame_tick=0. When en returns to 1, the scan resumes from the held
//   cnt/idx. If the resumed cnt is in DRIVE, the held snapshot is reused.
//  Exactly one dig_en bit is active in DRIVE; none is active in BLANK.
//  rst mid-slot: immediate blank. After release, the scan restarts at digit
//   0, cnt=0.
//  DIGITS=1: idx stays 0. frame_tick pulses every REFRESH_DIV cycles.
// TESTING (DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, EN_ACTIVE_LOW=1)
//  1. Reset, then en=1 with seg_in={7'h79,7'h24,7'h30,7'h40}:
//     - dig_en cycles 4'b1110, 4'b1101, 4'b1011, 4'b0111.
//     - Each digit is active for 6 cycles, then 2 blank cycles (all 1s).
//     - seg_out = 7'h40, 7'h30, 7'h24, 7'h79 in that order.
//  2. Frame period: frame_tick pulses once every 32 cycles, never twice in a
//     row, and never during the first frame.
//  3. Change digit-0 seg_in from 7'h40 to 7'h12 mid-DRIVE of digit 0:
//     - seg_out stays 7'h40 for the rest of the slot.
//     - 7'h12 appears on the next digit-0 visit.
//  4. Drop en for 5 cycles during digit-2 DRIVE:
//     - Next cycle: dig_en=4'b1111, seg_out=7'h7F.
//     - On en=1, digit 2 resumes and completes its remaining cycles.
//  5. Assert rst during digit-3 DRIVE:
//     - Same cycle: dig_en=4'b1111, seg_out=7'h7F.
//     - After release, the first active digit is digit 0, after 2 blank cycles.
//  6. Throughout all tests, assert: $countones(~dig_en) <= 1 every cycle, and
//     dig_en is inactive whenever seg_out is taken from the BLANK state.

Source files
------------

// File: rtl/sevseg_scan_mux.sv
// sevseg_scan_mux: round-robin seven-segment scanner with per-slot blanking and per-digit snapshot
module sevseg_scan_mux #(
  parameter int DIGITS        = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_CYCLES  = 16,
  parameter bit EN_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [7*DIGITS-1:0]   seg_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_tick
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] C_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] C_SNAP  = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] OFF = {DIGITS{EN_ACTIVE_LOW}};
  typedef enum logic {BLANK, DRIVE} state_t;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [6:0]        snap_seg, sel_seg;
  logic              snap_dp, sel_dp, pend;
  logic [DIGITS-1:0] onehot;
  state_t            state;
  always_comb begin
    sel_seg = 7'h7F;
    sel_dp  = 1'b1;
    onehot  = '0;
    state   = cnt < C_BLANK ? BLANK : DRIVE;
    for (int i = 0; i < DIGITS; i++) begin
      onehot[i] = idx == IW'(i);
      sel_seg   = idx == IW'(i) ? seg_in[7*i +: 7] : sel_seg;
      sel_dp    = idx == IW'(i) ? dp_in[i] : sel_dp;
    end
  end
  // pend marks a wrap so the tick lands on the first blank output cycle of digit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pend       <= 1'b0;
      snap_seg   <= 7'h7F;
      snap_dp    <= 1'b1;
      seg_out    <= 7'h7F;
      dp_out     <= 1'b1;
      dig_en     <= OFF;
      frame_tick <= 1'b0;
    end else if (en) begin
      cnt        <= cnt == C_LAST ? '0 : cnt + 1'b1;
      idx        <= cnt == C_LAST ? (idx == I_LAST ? '0 : idx + 1'b1) : idx;
      pend       <= (cnt == C_LAST && idx == I_LAST) ? 1'b1 : (cnt == '0 && idx == '0) ? 1'b0 : pend;
      frame_tick <= pend && cnt == '0 && idx == '0;
      snap_seg   <= cnt == C_SNAP ? sel_seg : snap_seg;
      snap_dp    <= cnt == C_SNAP ? sel_dp : snap_dp;
      seg_out    <= state == BLANK ? 7'h7F : snap_seg;
      dp_out     <= state == BLANK ? 1'b1 : snap_dp;
      dig_en     <= state == BLANK ? OFF : (EN_ACTIVE_LOW ? ~onehot : onehot);
    end else begin
      seg_out    <= 7'h7F;
      dp_out     <= 1'b1;
      dig_en     <= OFF;
      frame_tick <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sevseg_scan_mux.sv
// tb_sevseg_scan_mux: table-driven scan checks plus en-drop, snapshot and reset sequences
module tb_sevseg_scan_mux;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [27:0] seg_in = {7'h79, 7'h24, 7'h30, 7'h40};
  logic [3:0]  dp_in = 4'b0101;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_en;
  logic        frame_tick;
  int          checks = 0;
  int          errors = 0;
  int          m = 0;
  typedef struct {
    logic [3:0] den;
    logic [6:0] seg;
    logic       dp;
  } slot_t;
  slot_t tbl [4];

  sevseg_scan_mux #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .EN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .dp_in(dp_in),
    .seg_out(seg_out), .dp_out(dp_out), .dig_en(dig_en), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s m=%0d actual=%h expected=%h", name, m, act, exp);
    end
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_den"}, int'(dig_en), 4'hF);
    check({tag, "_seg"}, int'(seg_out), 7'h7F);
    check({tag, "_dp"}, int'(dp_out), 1);
    check({tag, "_ft"}, int'(frame_tick), 0);
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) begin
      en = e;
      @(posedge clk);
      #1;
      if (!e) check_blank("hold");
      else begin
        int slot = (m / 8) % 4;
        int ph = m % 8;
        check("den", int'(dig_en), ph < 2 ? 4'hF : int'(tbl[slot].den));
        check("seg", int'(seg_out), ph < 2 ? 7'h7F : int'(tbl[slot].seg));
        check("dp", int'(dp_out), ph < 2 ? 1 : int'(tbl[slot].dp));
        check("ft", int'(frame_tick), (ph == 0 && slot == 0 && m >= 32) ? 1 : 0);
        m++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ($countones(~dig_en) > 1) begin
        errors++;
        $display("FAIL onehot dig_en=%b expected at most one low bit", dig_en);
      end
    end
  end

  initial begin
    tbl[0] = '{4'b1110, 7'h40, 1'b1};
    tbl[1] = '{4'b1101, 7'h30, 1'b0};
    tbl[2] = '{4'b1011, 7'h24, 1'b1};
    tbl[3] = '{4'b0111, 7'h79, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    check_blank("reset");
    rst = 1'b0;
    run(64, 1'b1);
    run(5, 1'b1);
    seg_in[6:0] = 7'h12;
    run(3, 1'b1);
    tbl[0].seg = 7'h12;
    run(43, 1'b1);
    run(5, 1'b0);
    run(9, 1'b1);
    rst = 1'b1;
    #1;
    check_blank("rst_async");
    @(posedge clk);
    #1;
    check_blank("rst_hold");
    rst = 1'b0;
    m = 0;
    run(40, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
